rom_pipe: RTL and testbench



---
 rtl/rom_pipe.sv | 140 ++++++++++++++
 tb/tb_rom_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_pipe.sv
// rom_pipe: synchronous instruction ROM/RAM sitting between the IF stage and
// the instruction array. It answers a req/ready fetch handshake with a
// LATENCY-cycle response (1 or 2) and supports stall, flush and error
// reporting. A separate loader write port lets a debug/UART downloader fill
// the array at run time.
// Optional feature: define ROM_PARITY_EN to store an even-parity bit per word
// and flag parity mismatches on fetch.
module rom_pipe #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4096,
  parameter int                 LATENCY  = 1,
  parameter logic [DATA_W-1:0]  OOR_INST = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              err_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  localparam int               IDX_W      = $clog2(DEPTH);
  // First byte address past the end of the array; one extra bit so the
  // comparison cannot overflow when DEPTH*4 equals 2**ADDR_W.
  localparam logic [ADDR_W:0]  BYTE_LIMIT = (ADDR_W+1)'(DEPTH) << 2;

  // Storage array; never reset so a loaded program survives rst.
  logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef ROM_PARITY_EN
  logic              r_par [DEPTH];
`endif

  // Fetch-side decode.
  logic [IDX_W-1:0]  w_fIdx;
  logic              w_fMisalign;
  logic              w_fOutOfRange;
  logic              w_fParErr;
  logic              w_fErr;
  logic [DATA_W-1:0] w_fWord;
  logic              w_accept;
  logic              w_advance;

  // Loader-side decode.
  logic [IDX_W-1:0]  w_wIdx;
  logic              w_wOk;

  // Pipeline stage 1 (the fetch result register).
  logic              r_s1Valid;
  logic [DATA_W-1:0] r_s1Inst;
  logic              r_s1Err;

  assign ready_o       = !rst && !stall_i && !we_i;
  assign w_accept      = req_i && ready_o;
  // Flush beats stall: a flush always lets stage 1 load (the surviving
  // request or an empty slot) and clears everything downstream.
  assign w_advance     = flush_i || !stall_i;

  assign w_fIdx        = addr_i[IDX_W+1:2];
  assign w_fMisalign   = (addr_i[1:0] != 2'b00);
  assign w_fOutOfRange = ({1'b0, addr_i} >= BYTE_LIMIT);

  assign w_wIdx        = waddr_i[IDX_W+1:2];
  assign w_wOk         = we_i && (waddr_i[1:0] == 2'b00) && ({1'b0, waddr_i} < BYTE_LIMIT);

`ifdef ROM_PARITY_EN
  assign w_fParErr     = ((^r_mem[w_fIdx]) != r_par[w_fIdx]);
`else
  assign w_fParErr     = 1'b0;
`endif

  assign w_fErr        = w_fMisalign || w_fOutOfRange || w_fParErr;
  assign w_fWord       = w_fErr ? OOR_INST : r_mem[w_fIdx];

  // Loader writes; misaligned or out-of-range addresses are silently dropped.
  always_ff @(posedge clk) begin
    if (w_wOk) begin
      r_mem[w_wIdx] <= wdata_i;
`ifdef ROM_PARITY_EN
      r_par[w_wIdx] <= ^wdata_i;
`endif
    end
  end

  // Stage 1: capture an accepted fetch, hold on stall, reload on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Inst  <= '0;
      r_s1Err   <= 1'b0;
    end else if (w_advance) begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Inst <= w_fWord;
        r_s1Err  <= w_fErr;
      end
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic              r_s2Valid;
      logic [DATA_W-1:0] r_s2Inst;
      logic              r_s2Err;

      // Stage 2: extra output register; flush empties it, stall freezes it.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2Valid <= 1'b0;
          r_s2Inst  <= '0;
          r_s2Err   <= 1'b0;
        end else if (flush_i) begin
          r_s2Valid <= 1'b0;
        end else if (!stall_i) begin
          r_s2Valid <= r_s1Valid;
          if (r_s1Valid) begin
            r_s2Inst <= r_s1Inst;
            r_s2Err  <= r_s1Err;
          end
        end
      end

      assign inst_o       = r_s2Inst;
      assign inst_valid_o = r_s2Valid;
      assign err_o        = r_s2Err && r_s2Valid;
    end else begin : g_lat1
      assign inst_o       = r_s1Inst;
      assign inst_valid_o = r_s1Valid;
      assign err_o        = r_s1Err && r_s1Valid;
    end
  endgenerate

endmodule

// File: tb/tb_rom_pipe.sv
// tb_rom_pipe: drives one LATENCY=1 and one LATENCY=2 rom_pipe from the same
// stimulus and checks both against hand-computed expectations.
module tb_rom_pipe;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I0  = 32'h00500093;
  localparam logic [31:0] I1  = 32'h00108113;
  localparam logic [31:0] I2  = 32'h00000517;
  localparam int          NV  = 28;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        flush;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        expReady;
    logic        expValidA;
    logic [31:0] expInstA;
    logic        expErrA;
    logic        expValidB;
    logic [31:0] expInstB;
    logic        expErrB;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        stall;
  logic        flush;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  logic        readyA, validA, errA;
  logic [31:0] instA;
  logic        readyB, validB, errB;
  logic [31:0] instB;

  int totalCount;
  int badCount;

  vec_t vecs [NV];

  rom_pipe #(.LATENCY(1)) dutA (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .ready_o(readyA),
    .stall_i(stall), .flush_i(flush), .inst_o(instA), .inst_valid_o(validA),
    .err_o(errA), .we_i(we), .waddr_i(waddr), .wdata_i(wdata)
  );

  rom_pipe #(.LATENCY(2)) dutB (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .ready_o(readyB),
    .stall_i(stall), .flush_i(flush), .inst_o(instB), .inst_valid_o(validB),
    .err_o(errB), .we_i(we), .waddr_i(waddr), .wdata_i(wdata)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    totalCount++;
    if (got !== want) begin
      badCount++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req   = v.req;
    addr  = v.addr;
    stall = v.stall;
    flush = v.flush;
    we    = v.we;
    waddr = v.waddr;
    wdata = v.wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 1'b0; addr = '0; stall = 1'b0; flush = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
  endtask

  // Checks one DUT's response; inst/err only matter when valid is expected.
  task automatic checkResp(input string tag, input logic v, input logic [31:0] i, input logic e,
                           input logic ev, input logic [31:0] ei, input logic ee);
    checkOutput({tag, ".valid"}, {31'b0, v}, {31'b0, ev});
    if (ev) begin
      checkOutput({tag, ".inst"}, i, ei);
      checkOutput({tag, ".err"}, {31'b0, e}, {31'b0, ee});
    end
  endtask

  initial begin
    totalCount = 0;
    badCount   = 0;
    rst        = 1'b1;
    idle();

    //             req addr          stl flu we waddr         wdata          rdy vA   iA   eA   vB   iB   eB
    vecs[0]  = '{1'b1, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0,    I0,            1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h4,    I1,            1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h2,    32'hDEADBEEF,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h4000, 32'hCAFEBABE,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, I0,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h4,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, I1,    1'b0, 1'b1, I0,    1'b0};
    vecs[6]  = '{1'b1, 32'h2,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, NOP,   1'b1, 1'b1, I1,    1'b0};
    vecs[7]  = '{1'b1, 32'h4000, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, NOP,   1'b1, 1'b1, NOP,   1'b1};
    vecs[8]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 1'b1, NOP,   1'b1};
    vecs[9]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 32'h4,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, I1,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0, 1'b1, I1,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0, 1'b1, I1,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0, 1'b1, I1,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 1'b1, I1,    1'b0};
    vecs[15] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[16] = '{1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, I0,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[17] = '{1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, I0,    1'b0, 1'b1, I0,    1'b0};
    vecs[18] = '{1'b1, 32'h4,    1'b0, 1'b1, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, I1,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[19] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 1'b1, I1,    1'b0};
    vecs[20] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[21] = '{1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, I0,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[22] = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0,    32'h0,         1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[23] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[24] = '{1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, I0,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[25] = '{1'b1, 32'h4,    1'b0, 1'b0, 1'b1, 32'h8,    I2,            1'b0, 1'b0, 32'h0, 1'b0, 1'b1, I0,    1'b0};
    vecs[26] = '{1'b1, 32'h8,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b1, I2,    1'b0, 1'b0, 32'h0, 1'b0};
    vecs[27] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 32'h0, 1'b0, 1'b1, I2,    1'b0};

    // Reset state.
    tick();
    tick();
    checkOutput("reset.readyA", {31'b0, readyA}, 32'h0);
    checkOutput("reset.validA", {31'b0, validA}, 32'h0);
    checkOutput("reset.errA",   {31'b0, errA},   32'h0);
    checkOutput("reset.instA",  instA,           32'h0);
    checkOutput("reset.validB", {31'b0, validB}, 32'h0);
    checkOutput("reset.instB",  instB,           32'h0);
    rst = 1'b0;

    // Table-driven section: load, fetch, errors, stall, flush, write priority.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.readyA", i), {31'b0, readyA}, {31'b0, vecs[i].expReady});
      checkOutput($sformatf("v%0d.readyB", i), {31'b0, readyB}, {31'b0, vecs[i].expReady});
      @(posedge clk);
      #1;
      checkResp($sformatf("v%0d.A", i), validA, instA, errA,
                vecs[i].expValidA, vecs[i].expInstA, vecs[i].expErrA);
      checkResp($sformatf("v%0d.B", i), validB, instB, errB,
                vecs[i].expValidB, vecs[i].expInstB, vecs[i].expErrB);
    end

    // Reset with a fetch in flight: everything discarded, array kept.
    idle();
    req = 1'b1; addr = 32'h0;
    tick();
    checkResp("rstSeq.pre.A", validA, instA, errA, 1'b1, I0, 1'b0);
    addr = 32'h4;
    rst  = 1'b1;
    #1;
    checkOutput("rstSeq.readyA", {31'b0, readyA}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rstSeq.validA", {31'b0, validA}, 32'h0);
    checkOutput("rstSeq.instA",  instA,           32'h0);
    checkOutput("rstSeq.validB", {31'b0, validB}, 32'h0);
    rst  = 1'b0;
    addr = 32'h0;
    tick();
    checkResp("rstSeq.post.A", validA, instA, errA, 1'b1, I0, 1'b0);
    checkOutput("rstSeq.post.validB", {31'b0, validB}, 32'h0);
    req = 1'b0;
    tick();
    checkResp("rstSeq.post.B", validB, instB, errB, 1'b1, I0, 1'b0);
    checkOutput("rstSeq.post.validA", {31'b0, validA}, 32'h0);

`ifdef ROM_PARITY_EN
    // Corrupt the stored word at 0x4 behind the parity bit's back.
    dutA.r_mem[1] = dutA.r_mem[1] ^ 32'h00000100;
    dutB.r_mem[1] = dutB.r_mem[1] ^ 32'h00000100;
    req = 1'b1; addr = 32'h4;
    tick();
    checkResp("parity.A", validA, instA, errA, 1'b1, NOP, 1'b1);
    req = 1'b0;
    tick();
    checkResp("parity.B", validB, instB, errB, 1'b1, NOP, 1'b1);
`endif

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
